// File: rtl/osc_acq_sequencer_pkg.sv
// Shared types and defaults for the oscilloscope acquisition sequencer.
package osc_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } acq_state_e;

    localparam logic [3:0] TRIG_SEL_SW = 4'd0;

    localparam int CNT_W_DEF  = 32;
    localparam int ADDR_W_DEF = 14;
    localparam int N_SRC_DEF  = 8;
    localparam int MISS_W     = 16;

endpackage

// File: rtl/osc_acq_sequencer_if.sv
// Register-bank, trigger and capture-buffer signals seen by the sequencer.
interface osc_acq_sequencer_if
    import osc_acq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_SRC  = N_SRC_DEF
);

    logic              arm_i;
    logic              abort_i;
    logic              sw_trig_i;
    logic [N_SRC-1:0]  trig_src_i;
    logic [3:0]        trig_sel_i;
    logic [CNT_W-1:0]  pre_i;
    logic [CNT_W-1:0]  post_i;
    logic [CNT_W-1:0]  cycles_i;
    logic              dec_en_i;
    logic              ack_i;
    logic              we_o;
    logic [ADDR_W-1:0] wptr_o;
    logic [ADDR_W-1:0] tptr_o;
    logic              armed_o;
    logic              trig_o;
    logic              irq_o;
    logic [CNT_W-1:0]  cyc_cnt_o;
    logic [MISS_W-1:0] miss_o;

    modport master (
        output arm_i, abort_i, sw_trig_i, trig_src_i, trig_sel_i,
               pre_i, post_i, cycles_i, dec_en_i, ack_i,
        input  we_o, wptr_o, tptr_o, armed_o, trig_o, irq_o, cyc_cnt_o, miss_o
    );

    modport slave (
        input  arm_i, abort_i, sw_trig_i, trig_src_i, trig_sel_i,
               pre_i, post_i, cycles_i, dec_en_i, ack_i,
        output we_o, wptr_o, tptr_o, armed_o, trig_o, irq_o, cyc_cnt_o, miss_o
    );

endinterface

// File: rtl/osc_acq_sequencer_trig_edge.sv
// Rising-edge detector over the hardware trigger sources, muxed by the
// selected source and OR-ed with the software trigger.
module osc_trig_edge
    import osc_acq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF
) (
    input  logic             clk0,
    input  logic             rstn,
    input  logic [N_SRC-1:0] trig_src_i,
    input  logic [3:0]       trig_sel_i,
    input  logic             sw_trig_i,
    output logic             trig_ev_o
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] rise;
    logic             hw_hit;

    always_ff @(posedge clk0) begin
        if (!rstn) begin
            src_q <= '0;
        end else begin
            src_q <= trig_src_i;
        end
    end

    // Selector values outside 1..N_SRC match no source, leaving software only.
    always_comb begin
        rise   = trig_src_i & ~src_q;
        hw_hit = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (trig_sel_i != TRIG_SEL_SW && trig_sel_i == 4'(k + 1) && rise[k]) begin
                hw_hit = 1'b1;
            end
        end
    end

    assign trig_ev_o = sw_trig_i | hw_hit;

endmodule

// File: rtl/osc_acq_sequencer.sv
// Acquisition sequencer: arm, pre-trigger fill, trigger wait, post-trigger
// capture, then interrupt and acknowledge before re-arming.
module osc_acq_sequencer
    import osc_acq_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_SRC  = N_SRC_DEF
) (
    input logic                clk0,
    input logic                rstn,
    osc_acq_sequencer_if.slave bus
);

    acq_state_e        state_q;
    logic [3:0]        sel_q;
    logic [CNT_W-1:0]  pre_q, post_q, cycles_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] tptr_q;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              irq_q;
    logic              we;
    logic              trig_ev;

    osc_trig_edge #(.N_SRC(N_SRC)) u_trig_edge (
        .clk0       (clk0),
        .rstn       (rstn),
        .trig_src_i (bus.trig_src_i),
        .trig_sel_i (sel_q),
        .sw_trig_i  (bus.sw_trig_i),
        .trig_ev_o  (trig_ev)
    );

    always_comb begin
        we     = bus.dec_en_i && (state_q inside {ST_PRE, ST_WAIT, ST_POST});
        wptr_d = wptr_q + ADDR_W'(we);
        cnt_d  = cnt_q + CNT_W'(1);
        cyc_d  = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
        miss_d = (&miss_q) ? miss_q : miss_q + MISS_W'(1);
    end

    // cnt_q counts strobes within PRE and within POST; the trigger sample
    // itself is post sample 0 and is never counted.
    always_ff @(posedge clk0) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            pre_q    <= '0;
            post_q   <= '0;
            cycles_q <= '0;
            cnt_q    <= '0;
            cyc_q    <= '0;
            wptr_q   <= '0;
            tptr_q   <= '0;
            miss_q   <= '0;
            irq_q    <= 1'b0;
        end else if (bus.abort_i) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            wptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            wptr_q <= wptr_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.arm_i) begin
                        sel_q    <= bus.trig_sel_i;
                        pre_q    <= bus.pre_i;
                        post_q   <= bus.post_i;
                        cycles_q <= bus.cycles_i;
                        cyc_q    <= '0;
                        miss_q   <= '0;
                        cnt_q    <= '0;
                        state_q  <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (trig_ev) begin
                        miss_q <= miss_d;
                    end
                    if (bus.dec_en_i) begin
                        cnt_q <= cnt_d;
                    end
                    if (pre_q == '0 || (bus.dec_en_i && cnt_d == pre_q)) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (trig_ev) begin
                        tptr_q <= wptr_q;
                        cnt_q  <= '0;
                        if (post_q == '0) begin
                            irq_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (bus.dec_en_i) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == post_q) begin
                            irq_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.ack_i) begin
                        irq_q   <= 1'b0;
                        cyc_q   <= cyc_d;
                        cnt_q   <= '0;
                        state_q <= (cycles_q != '0 && cyc_d == cycles_q) ? ST_IDLE : ST_PRE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.we_o      = we;
    assign bus.wptr_o    = wptr_q;
    assign bus.tptr_o    = tptr_q;
    assign bus.armed_o   = (state_q == ST_PRE) || (state_q == ST_WAIT);
    assign bus.trig_o    = (state_q == ST_POST);
    assign bus.irq_o     = irq_q;
    assign bus.cyc_cnt_o = cyc_q;
    assign bus.miss_o    = miss_q;

endmodule

// File: tb/tb_osc_acq_sequencer.sv
// Scenario bench for osc_acq_sequencer; expected pointers and counts are
// derived arithmetically from the stimulus each scenario applies.
module tb_osc_acq_sequencer;
    import osc_acq_pkg::*;

    localparam int CNT_W  = 32;
    localparam int ADDR_W = 4;
    localparam int N_SRC  = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk0 = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   wrCnt  = 0;
    int   wExp   = 0;

    osc_acq_sequencer_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .N_SRC(N_SRC)) bus ();

    osc_acq_sequencer #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .N_SRC(N_SRC)) dut (
        .clk0 (clk0),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk0 = ~clk0;

    // Buffer writes as seen by the capture memory, one per high we_o cycle.
    always @(negedge clk0) begin
        if (bus.we_o === 1'b1) wrCnt++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic idleInputs();
        bus.arm_i      = 1'b0;
        bus.abort_i    = 1'b0;
        bus.sw_trig_i  = 1'b0;
        bus.trig_src_i = '0;
        bus.trig_sel_i = '0;
        bus.pre_i      = '0;
        bus.post_i     = '0;
        bus.cycles_i   = '0;
        bus.dec_en_i   = 1'b0;
        bus.ack_i      = 1'b0;
    endtask

    task automatic doAbort();
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        wExp = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.we_o, bus.wptr_o, bus.tptr_o, bus.armed_o, bus.trig_o, bus.irq_o,
             bus.cyc_cnt_o, bus.miss_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got we=%b wptr=%0d tptr=%0d armed=%b trig=%b irq=%b cyc=%0d miss=%0d want all 0",
                     bus.we_o, bus.wptr_o, bus.tptr_o, bus.armed_o, bus.trig_o, bus.irq_o, bus.cyc_cnt_o, bus.miss_o);
        end
        rstn = 1'b1;
        step();
    endtask

    // Single acquisition, dec_en always high, software trigger d cycles after arm.
    task automatic test_sw_trigger(input int pre, input int post, input int d);
        int base;
        int startW;
        base   = wExp;
        startW = wrCnt;
        bus.trig_sel_i = TRIG_SEL_SW;
        bus.pre_i      = CNT_W'(pre);
        bus.post_i     = CNT_W'(post);
        bus.cycles_i   = CNT_W'(1);
        bus.dec_en_i   = 1'b1;
        bus.arm_i      = 1'b1;
        step();
        bus.arm_i = 1'b0;
        checks++;
        if (bus.armed_o !== 1'b1 || bus.trig_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_armed: got armed=%b trig=%b want armed=1 trig=0", bus.armed_o, bus.trig_o);
        end
        repeat (d - 1) step();
        checks++;
        if (bus.armed_o !== 1'b1 || bus.trig_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_waiting: got armed=%b trig=%b want armed=1 trig=0", bus.armed_o, bus.trig_o);
        end
        bus.sw_trig_i = 1'b1;
        step();
        bus.sw_trig_i = 1'b0;
        checks++;
        if (bus.trig_o !== 1'b1 || bus.tptr_o !== ADDR_W'((base + d - 1) % DEPTH)) begin
            errors++;
            $display("[TB] FAIL sw_tptr: got trig=%b tptr=%0d want trig=1 tptr=%0d",
                     bus.trig_o, bus.tptr_o, (base + d - 1) % DEPTH);
        end
        repeat (post - 1) step();
        checks++;
        if (bus.irq_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_irq_early: got irq=%b want 0", bus.irq_o);
        end
        step();
        checks++;
        if (bus.irq_o !== 1'b1 || bus.we_o !== 1'b0 || bus.trig_o !== 1'b0 ||
            bus.wptr_o !== ADDR_W'((base + d + post) % DEPTH)) begin
            errors++;
            $display("[TB] FAIL sw_done: got irq=%b we=%b trig=%b wptr=%0d want irq=1 we=0 trig=0 wptr=%0d",
                     bus.irq_o, bus.we_o, bus.trig_o, bus.wptr_o, (base + d + post) % DEPTH);
        end
        checks++;
        if (wrCnt - startW !== d + post) begin
            errors++;
            $display("[TB] FAIL sw_writes: got %0d want %0d", wrCnt - startW, d + post);
        end
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        checks++;
        if (bus.irq_o !== 1'b0 || bus.cyc_cnt_o !== CNT_W'(1) || bus.armed_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_ack: got irq=%b cyc=%0d armed=%b want irq=0 cyc=1 armed=0",
                     bus.irq_o, bus.cyc_cnt_o, bus.armed_o);
        end
        wExp = (base + d + post) % DEPTH;
    endtask

    task automatic test_wrap();
        doAbort();
        test_sw_trigger(25, 14, 27);
    endtask

    task automatic test_src_edge();
        int k;
        int other;
        int post;
        bit sawTrig;
        doAbort();
        k     = $urandom_range(1, N_SRC);
        other = (k % N_SRC) + 1;
        post  = $urandom_range(1, 5);
        bus.trig_sel_i = 4'(k);
        bus.pre_i      = CNT_W'(4);
        bus.post_i     = CNT_W'(post);
        bus.cycles_i   = '0;
        bus.dec_en_i   = 1'b1;
        bus.arm_i      = 1'b1;
        step();
        bus.arm_i = 1'b0;
        step();
        bus.trig_src_i[k-1] = 1'b1;
        step();
        bus.trig_src_i[k-1] = 1'b0;
        checks++;
        if (bus.miss_o !== 16'd1 || bus.trig_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL src_miss: got miss=%0d trig=%b want miss=1 trig=0", bus.miss_o, bus.trig_o);
        end
        repeat (2) step();
        bus.trig_src_i[other-1] = 1'b1;
        bus.arm_i = 1'b1;
        bus.ack_i = 1'b1;
        bus.pre_i = CNT_W'(9);
        step();
        bus.trig_src_i[other-1] = 1'b0;
        bus.arm_i = 1'b0;
        bus.ack_i = 1'b0;
        checks++;
        if (bus.trig_o !== 1'b0 || bus.armed_o !== 1'b1 || bus.miss_o !== 16'd1 || bus.cyc_cnt_o !== '0) begin
            errors++;
            $display("[TB] FAIL src_ignored: got trig=%b armed=%b miss=%0d cyc=%0d want trig=0 armed=1 miss=1 cyc=0",
                     bus.trig_o, bus.armed_o, bus.miss_o, bus.cyc_cnt_o);
        end
        step();
        bus.trig_src_i[k-1] = 1'b1;
        step();
        checks++;
        if (bus.trig_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL src_trig: got trig=%b want 1 (source %0d)", bus.trig_o, k);
        end
        repeat (post) step();
        checks++;
        if (bus.irq_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL src_irq: got irq=%b want 1", bus.irq_o);
        end
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        checks++;
        if (bus.armed_o !== 1'b1 || bus.irq_o !== 1'b0 || bus.cyc_cnt_o !== CNT_W'(1)) begin
            errors++;
            $display("[TB] FAIL src_rearm: got armed=%b irq=%b cyc=%0d want armed=1 irq=0 cyc=1",
                     bus.armed_o, bus.irq_o, bus.cyc_cnt_o);
        end
        sawTrig = 1'b0;
        repeat (16) begin
            step();
            if (bus.trig_o === 1'b1) sawTrig = 1'b1;
        end
        checks++;
        if (sawTrig !== 1'b0 || bus.miss_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL src_held_level: got retrig=%b miss=%0d want retrig=0 miss=1", sawTrig, bus.miss_o);
        end
        bus.trig_src_i = '0;
        doAbort();
    endtask

    task automatic test_cycles();
        int pre;
        int post;
        int n;
        doAbort();
        pre  = $urandom_range(1, 4);
        post = $urandom_range(1, 4);
        bus.trig_sel_i = TRIG_SEL_SW;
        bus.pre_i      = CNT_W'(pre);
        bus.post_i     = CNT_W'(post);
        bus.cycles_i   = CNT_W'(3);
        bus.dec_en_i   = 1'b1;
        bus.arm_i      = 1'b1;
        step();
        bus.arm_i    = 1'b0;
        bus.cycles_i = '0;
        for (int acq = 1; acq <= 3; acq++) begin
            repeat (pre + 2) step();
            bus.sw_trig_i = 1'b1;
            step();
            bus.sw_trig_i = 1'b0;
            n = 0;
            while (bus.irq_o !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            checks++;
            if (bus.irq_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL cyc_irq: acquisition %0d got irq=%b want 1 within 40 cycles", acq, bus.irq_o);
            end
            repeat (500) step();
            checks++;
            if (bus.irq_o !== 1'b1 || bus.we_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cyc_irq_hold: got irq=%b we=%b want irq=1 we=0", bus.irq_o, bus.we_o);
            end
            bus.ack_i = 1'b1;
            step();
            bus.ack_i = 1'b0;
            checks++;
            if (bus.cyc_cnt_o !== CNT_W'(acq) || bus.irq_o !== 1'b0 || bus.armed_o !== (acq < 3)) begin
                errors++;
                $display("[TB] FAIL cyc_count: got cyc=%0d irq=%b armed=%b want cyc=%0d irq=0 armed=%b",
                         bus.cyc_cnt_o, bus.irq_o, bus.armed_o, acq, (acq < 3));
            end
        end
        repeat (5) step();
        checks++;
        if (bus.armed_o !== 1'b0 || bus.cyc_cnt_o !== CNT_W'(3)) begin
            errors++;
            $display("[TB] FAIL cyc_idle: got armed=%b cyc=%0d want armed=0 cyc=3", bus.armed_o, bus.cyc_cnt_o);
        end
        bus.arm_i = 1'b1;
        step();
        bus.arm_i = 1'b0;
        for (int acq = 1; acq <= 4; acq++) begin
            repeat (pre + 2) step();
            bus.sw_trig_i = 1'b1;
            step();
            bus.sw_trig_i = 1'b0;
            repeat (post + 2) step();
            bus.ack_i = 1'b1;
            step();
            bus.ack_i = 1'b0;
        end
        checks++;
        if (bus.armed_o !== 1'b1 || bus.cyc_cnt_o !== CNT_W'(4)) begin
            errors++;
            $display("[TB] FAIL cont_rearm: got armed=%b cyc=%0d want armed=1 cyc=4", bus.armed_o, bus.cyc_cnt_o);
        end
        doAbort();
    endtask

    // Sparse strobes with empty pre/post windows: trigger lands straight in DONE.
    task automatic test_sparse();
        int ph;
        int tIdx;
        int nPre;
        int nAll;
        bit dec;
        doAbort();
        ph   = $urandom_range(0, 31);
        tIdx = $urandom_range(2, 90);
        nPre = 0;
        nAll = 0;
        bus.trig_sel_i = TRIG_SEL_SW;
        bus.pre_i      = '0;
        bus.post_i     = '0;
        bus.cycles_i   = CNT_W'(1);
        bus.dec_en_i   = 1'b0;
        bus.arm_i      = 1'b1;
        step();
        bus.arm_i = 1'b0;
        for (int c = 1; c <= tIdx; c++) begin
            dec = ((c + ph) % 32 == 0);
            bus.dec_en_i  = dec;
            bus.sw_trig_i = (c == tIdx);
            if (dec) nAll++;
            if (dec && c < tIdx) nPre++;
            if (c == 2) begin
                checks++;
                if (bus.armed_o !== 1'b1 || bus.trig_o !== 1'b0 || bus.irq_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sparse_armed: got armed=%b trig=%b irq=%b want armed=1 trig=0 irq=0",
                             bus.armed_o, bus.trig_o, bus.irq_o);
                end
            end
            step();
        end
        bus.dec_en_i  = 1'b0;
        bus.sw_trig_i = 1'b0;
        checks++;
        if (bus.irq_o !== 1'b1 || bus.trig_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sparse_done: got irq=%b trig=%b want irq=1 trig=0", bus.irq_o, bus.trig_o);
        end
        checks++;
        if (bus.tptr_o !== ADDR_W'(nPre % DEPTH) || bus.wptr_o !== ADDR_W'(nAll % DEPTH)) begin
            errors++;
            $display("[TB] FAIL sparse_ptrs: got tptr=%0d wptr=%0d want tptr=%0d wptr=%0d",
                     bus.tptr_o, bus.wptr_o, nPre % DEPTH, nAll % DEPTH);
        end
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        wExp = nAll % DEPTH;
    endtask

    task automatic test_abort_arm();
        doAbort();
        bus.trig_sel_i = TRIG_SEL_SW;
        bus.pre_i      = CNT_W'(2);
        bus.post_i     = CNT_W'(20);
        bus.cycles_i   = CNT_W'(1);
        bus.dec_en_i   = 1'b1;
        bus.arm_i      = 1'b1;
        step();
        bus.arm_i = 1'b0;
        repeat (4) step();
        bus.sw_trig_i = 1'b1;
        step();
        bus.sw_trig_i = 1'b0;
        repeat (2) step();
        checks++;
        if (bus.trig_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_in_post: got trig=%b want 1", bus.trig_o);
        end
        bus.abort_i = 1'b1;
        bus.arm_i   = 1'b1;
        step();
        bus.abort_i = 1'b0;
        bus.arm_i   = 1'b0;
        #1;
        checks++;
        if ({bus.we_o, bus.armed_o, bus.trig_o, bus.irq_o, bus.wptr_o} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_status: got we=%b armed=%b trig=%b irq=%b wptr=%0d want all 0",
                     bus.we_o, bus.armed_o, bus.trig_o, bus.irq_o, bus.wptr_o);
        end
        bus.arm_i = 1'b1;
        step();
        bus.arm_i = 1'b0;
        checks++;
        if (bus.armed_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_rearm: got armed=%b want 1", bus.armed_o);
        end
        doAbort();
    endtask

    task automatic test_reset_midrun();
        bus.trig_sel_i = TRIG_SEL_SW;
        bus.pre_i      = CNT_W'(6);
        bus.dec_en_i   = 1'b1;
        bus.arm_i      = 1'b1;
        step();
        bus.arm_i     = 1'b0;
        bus.sw_trig_i = 1'b1;
        step();
        bus.sw_trig_i = 1'b0;
        checks++;
        if (bus.miss_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL rst_pre_miss: got miss=%0d want 1", bus.miss_o);
        end
        rstn = 1'b0;
        step();
        checks++;
        if ({bus.wptr_o, bus.tptr_o, bus.armed_o, bus.trig_o, bus.irq_o,
             bus.cyc_cnt_o, bus.miss_o} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_midrun: got wptr=%0d tptr=%0d armed=%b trig=%b irq=%b cyc=%0d miss=%0d want all 0",
                     bus.wptr_o, bus.tptr_o, bus.armed_o, bus.trig_o, bus.irq_o, bus.cyc_cnt_o, bus.miss_o);
        end
        rstn = 1'b1;
        step();
        wExp = 0;
    endtask

    initial begin
        int pre;
        idleInputs();
        test_reset();
        for (int i = 0; i < 3; i++) begin
            pre = $urandom_range(1, 6);
            test_sw_trigger(pre, $urandom_range(1, 10), pre + 1 + $urandom_range(0, 12));
        end
        test_wrap();
        test_src_edge();
        test_cycles();
        test_sparse();
        test_abort_arm();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
